poci_uart: RTL and testbench

POCI_UART -- requirements
Module: poci_uart

---
 rtl/poci_uart.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_poci_uart.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poci_uart.sv
// POCI-attached UART: 8N1 transmitter with TX FIFO, optional receiver, zero-wait-state register port.
// Define POCI_UART_RX_EN to build the receiver; without it uart_rxd is unused and RX status/data read 0.
module poci_uart #(
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned DEFAULT_DIV = 174
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [3:2]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    localparam int unsigned AW = $clog2(TX_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // bus decode: side effects only in the access-phase cycle
    logic w_acc, w_wr, w_rd;
    logic w_data_wr, w_data_rd, w_sts_wr, w_div_wr;
    assign w_acc     = psel & penable;
    assign w_wr      = w_acc & pwrite;
    assign w_rd      = w_acc & ~pwrite & presetn;
    assign w_data_wr = w_wr & (paddr == 2'b00);
    assign w_data_rd = w_rd & (paddr == 2'b00);
    assign w_sts_wr  = w_wr & (paddr == 2'b01);
    assign w_div_wr  = w_wr & (paddr == 2'b10);
    assign pready    = 1'b1;

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_eff;
    assign w_div_eff = (r_div < DW'(2)) ? DW'(2) : r_div;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)      r_div <= DW'(DEFAULT_DIV);
        else if (w_div_wr) r_div <= pwdata[DW-1:0];
    end

    // TX FIFO; a push into a full FIFO still succeeds when the transmitter pops that cycle
    logic [7:0]    r_mem [TX_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic          w_full, w_empty, w_push, w_pop, w_ovf_set;
    logic [7:0]    w_head;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = ((r_wptr - r_rptr) == PW'(TX_DEPTH));
    assign w_push    = w_data_wr & (~w_full | w_pop);
    assign w_ovf_set = w_data_wr & w_full & ~w_pop;
    assign w_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= pwdata[7:0];
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // transmitter
    tx_state_t     r_tx_state, w_tx_state_n;
    logic [DW-1:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]    r_tx_bit, w_tx_bit_n;
    logic [7:0]    r_tx_shift, w_tx_shift_n;
    logic          r_txd, w_txd_n, w_tx_last;
    assign w_tx_last = (r_tx_cnt == r_tx_div - DW'(1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= DW'(2);
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_div   <= w_tx_div_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_txd      <= w_txd_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + DW'(1);
        w_tx_div_n   = r_tx_div;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_txd_n      = r_txd;
        w_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tx_state_n = TX_START;
                    w_tx_shift_n = w_head;
                    w_tx_div_n   = w_div_eff;
                    w_txd_n      = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_last) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_txd_n      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_last) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_txd_n      = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = r_tx_shift >> 1;
                        w_txd_n      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_last) begin
                    w_tx_cnt_n = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_tx_state_n = TX_START;
                        w_tx_shift_n = w_head;
                        w_tx_div_n   = w_div_eff;
                        w_txd_n      = 1'b0;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_state_n = TX_IDLE;
                w_txd_n      = 1'b1;
            end
        endcase
    end

    assign uart_txd = r_txd;

    logic r_txovf;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                     r_txovf <= 1'b0;
        else if (w_ovf_set)               r_txovf <= 1'b1;
        else if (w_sts_wr && pwdata[3])   r_txovf <= 1'b0;
    end

    logic       w_rxv, w_rxovr, w_ferr;
    logic [7:0] w_rx_byte;

`ifdef POCI_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // two-flop synchronizer plus one history flop for edge detection
    logic r_rx_s1, r_rx_s2, r_rx_prev;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    rx_state_t     r_rx_state, w_rx_state_n;
    logic [DW-1:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n;
    logic [2:0]    r_rx_bit, w_rx_bit_n;
    logic [7:0]    r_rx_shift, w_rx_shift_n;
    logic          w_rx_mid, w_rx_last, w_rx_done, w_rx_ferr;
    assign w_rx_mid  = (r_rx_cnt == {1'b0, r_rx_div[DW-1:1]} - DW'(1));
    assign w_rx_last = (r_rx_cnt == r_rx_div - DW'(1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= DW'(2);
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_div   <= w_rx_div_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + DW'(1);
        w_rx_div_n   = r_rx_div;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_done    = 1'b0;
        w_rx_ferr    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = '0;
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_n = RX_START;
                    w_rx_div_n   = w_div_eff;
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_last) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_bit_n   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_last) begin
                    w_rx_state_n = RX_IDLE;
                    w_rx_done    = r_rx_s2;
                    w_rx_ferr    = ~r_rx_s2;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // a read that clears RXV in the completion cycle lets the new byte in without overrun
    logic       r_rxv, r_rxovr, r_ferr;
    logic [7:0] r_rx_byte;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rxv     <= 1'b0;
            r_rxovr   <= 1'b0;
            r_ferr    <= 1'b0;
            r_rx_byte <= '0;
        end else begin
            if (w_rx_done && (!r_rxv || w_data_rd)) begin
                r_rxv     <= 1'b1;
                r_rx_byte <= r_rx_shift;
            end else if (w_data_rd) begin
                r_rxv <= 1'b0;
            end
            if (w_rx_done && r_rxv && !w_data_rd) r_rxovr <= 1'b1;
            else if (w_sts_wr && pwdata[4])      r_rxovr <= 1'b0;
            if (w_rx_ferr)                       r_ferr <= 1'b1;
            else if (w_sts_wr && pwdata[5])      r_ferr <= 1'b0;
        end
    end

    assign w_rxv     = r_rxv;
    assign w_rxovr   = r_rxovr;
    assign w_ferr    = r_ferr;
    assign w_rx_byte = r_rx_byte;

    logic w_unused;
    assign w_unused = ^pwdata[31:16];
`else
    assign w_rxv     = 1'b0;
    assign w_rxovr   = 1'b0;
    assign w_ferr    = 1'b0;
    assign w_rx_byte = 8'd0;

    logic w_unused;
    assign w_unused = ^{pwdata[31:16], pwdata[5:4], uart_rxd, w_data_rd};
`endif

    logic        w_txbusy;
    logic [31:0] w_rdata;
    assign w_txbusy = ~w_empty | (r_tx_state != TX_IDLE);

    always_comb begin
        w_rdata = '0;
        case (paddr)
            2'b00:   w_rdata = w_rxv ? {24'd0, w_rx_byte} : 32'd0;
            2'b01:   w_rdata = {26'd0, w_ferr, w_rxovr, r_txovf, w_rxv, w_txbusy, w_full};
            2'b10:   w_rdata = {16'd0, r_div};
            default: w_rdata = '0;
        endcase
    end

    assign prdata = w_rd ? w_rdata : 32'd0;

endmodule

// File: tb/tb_poci_uart.sv
// Self-checking bench for poci_uart: directed TX/RX/reset scenarios with randomized bytes and divisors.
module tb_poci_uart;

    localparam int unsigned DEPTH = 8;
    localparam logic [1:0]  A_DATA = 2'b00, A_STS = 2'b01, A_DIV = 2'b10, A_RSV = 2'b11;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [1:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, uart_txd;
    logic        uart_rxd = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    poci_uart #(.TX_DEPTH(DEPTH), .DEFAULT_DIV(174)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 pclk = ~pclk;

    // line recorder, aligned to the first start bit seen while armed
    logic rec_arm = 1'b0;
    logic rec_q[$];
    always @(negedge pclk) begin
        if (rec_arm && (rec_q.size() > 0 || uart_txd == 1'b0)) rec_q.push_back(uart_txd);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wave(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        d = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    // One frame from an idle, empty transmitter; expected line built from the byte and bit time.
    task automatic tx_frame(input string tag, input logic [7:0] b, input int de);
        logic [319:0] got, exp;
        got = '0; exp = '0;
        apb_write(A_DATA, {24'd0, b});
        check({tag, "_lat1"}, 32'(uart_txd), 32'd1);
        for (int i = 0; i < 9 * de; i++) begin
            @(posedge pclk); #1;
            got[i] = uart_txd;
            exp[i] = (i < de) ? 1'b0 : b[(i - de) / de];
        end
        check_wave({tag, "_wave"}, got, exp);
        read_check({tag, "_busy_stop"}, A_STS, 32'h02);
        check({tag, "_stop_lvl"}, 32'(uart_txd), 32'd1);
        repeat (de) @(posedge pclk);
        #1;
        read_check({tag, "_idle"}, A_STS, 32'h00);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int de);
        for (int k = 0; k < 10; k++) begin
            uart_rxd = (k == 0) ? 1'b0 : (k < 9) ? b[k - 1] : stop;
            repeat (de) begin @(posedge pclk); #1; end
        end
        uart_rxd = 1'b1;
        repeat (4) begin @(posedge pclk); #1; end
    endtask

    function automatic logic [9:0] decode(input int base, input int de);
        logic [9:0] f;
        for (int k = 0; k < 10; k++) f[k] = rec_q[base + k * de + de / 2];
        return f;
    endfunction

    initial begin
        logic [7:0]  bytes [10];
        logic [7:0]  b, b2;
        int          de;
        int          n_acc;

        // reset state
        #12;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_pready", 32'(pready), 32'd1);
        check("rst_prdata", prdata, 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        read_check("rst_div", A_DIV, 32'd174);
        read_check("rst_sts", A_STS, 32'd0);
        read_check("rst_data", A_DATA, 32'd0);
        read_check("rsv_read", A_RSV, 32'd0);

        // prdata stays 0 outside the access phase
        @(posedge pclk); #1;
        psel = 1'b1; paddr = A_DIV;
        #2;
        check("setup_prdata", prdata, 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0;

        // DIV register storage and reserved-write immunity
        apb_write(A_RSV, 32'hFFFF_FFFF);
        read_check("rsv_after_wr", A_RSV, 32'd0);
        apb_write(A_DIV, 32'h1234_0001);
        read_check("div_rw", A_DIV, 32'h0001);

        // DIV=1 transmits at the minimum bit time of 2
        tx_frame("tx_div1", 8'($urandom), 2);

        apb_write(A_DIV, 32'd4);
        tx_frame("tx_55", 8'h55, 4);

        for (int k = 0; k < 3; k++) begin
            de = $urandom_range(2, 12);
            apb_write(A_DIV, 32'(de));
            tx_frame("tx_rand", 8'($urandom), de);
        end

        // burst: one frame in flight, then DEPTH+1 writes overflow the FIFO by one
        apb_write(A_DIV, 32'd16);
        rec_q.delete();
        rec_arm = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bytes[k] = 8'($urandom);
            apb_write(A_DATA, {24'd0, bytes[k]});
        end
        n_acc = (10 > DEPTH + 1) ? DEPTH + 1 : 10;
        read_check("burst_full_ovf", A_STS, 32'h0B);
        repeat (n_acc * 160 + 40) @(posedge pclk);
        #1;
        rec_arm = 1'b0;
        check("burst_rec_len", 32'(rec_q.size() >= n_acc * 160 + 16), 32'd1);
        for (int f = 0; f < n_acc; f++) begin
            check($sformatf("burst_frame%0d", f), 32'(decode(f * 160, 16)), {22'd0, 1'b1, bytes[f], 1'b0});
        end
        check("burst_tail_idle", 32'(rec_q[n_acc * 160 + 8]), 32'd1);
        read_check("burst_sts_ovf", A_STS, 32'h08);
        apb_write(A_STS, 32'h08);
        read_check("burst_ovf_clr", A_STS, 32'h00);

`ifdef POCI_UART_RX_EN
        apb_write(A_DIV, 32'd8);
        rx_send(8'hA3, 1'b1, 8);
        read_check("rx_a3_rxv", A_STS, 32'h04);
        read_check("rx_a3_data", A_DATA, 32'hA3);
        read_check("rx_a3_clr", A_STS, 32'h00);

        for (int k = 0; k < 3; k++) begin
            de = $urandom_range(4, 12);
            b = 8'($urandom);
            apb_write(A_DIV, 32'(de));
            rx_send(b, 1'b1, de);
            read_check("rx_rand_sts", A_STS, 32'h04);
            read_check("rx_rand_data", A_DATA, {24'd0, b});
        end

        apb_write(A_DIV, 32'd8);
        b = 8'($urandom); b2 = ~b;
        rx_send(b, 1'b1, 8);
        rx_send(b2, 1'b1, 8);
        read_check("rx_ovr_sts", A_STS, 32'h14);
        read_check("rx_ovr_keep", A_DATA, {24'd0, b});
        apb_write(A_STS, 32'h10);
        read_check("rx_ovr_clr", A_STS, 32'h00);

        rx_send(8'h5A, 1'b0, 8);
        read_check("rx_ferr", A_STS, 32'h20);
        read_check("rx_ferr_data", A_DATA, 32'd0);
        apb_write(A_STS, 32'h20);
        read_check("rx_ferr_clr", A_STS, 32'h00);

        uart_rxd = 1'b0;
        @(posedge pclk); #1;
        uart_rxd = 1'b1;
        repeat (20) @(posedge pclk);
        #1;
        read_check("rx_glitch_sts", A_STS, 32'h00);
        read_check("rx_glitch_data", A_DATA, 32'd0);
`else
        apb_write(A_DIV, 32'd8);
        rx_send(8'hA3, 1'b1, 8);
        read_check("norx_sts", A_STS, 32'h00);
        read_check("norx_data", A_DATA, 32'd0);
        rx_send(8'h5A, 1'b0, 8);
        read_check("norx_ferr", A_STS, 32'h00);
`endif

        // reset in the middle of a frame with bytes still queued
        apb_write(A_DIV, 32'd20);
        apb_write(A_DATA, 32'h00);
        apb_write(A_DATA, 32'hFF);
        apb_write(A_DATA, 32'h12);
        check("mid_txd_low", 32'(uart_txd), 32'd0);
        presetn = 1'b0;
        #1;
        check("mid_rst_txd", 32'(uart_txd), 32'd1);
        check("mid_rst_prdata", prdata, 32'd0);
        check("mid_rst_pready", 32'(pready), 32'd1);
        repeat (3) @(posedge pclk);
        #1;
        presetn = 1'b1;
        read_check("mid_div", A_DIV, 32'd174);
        read_check("mid_sts", A_STS, 32'd0);
        repeat (50) @(posedge pclk);
        #1;
        check("mid_idle_txd", 32'(uart_txd), 32'd1);
        read_check("mid_flushed", A_STS, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
